// File: rtl/board_cell_fetch_if.sv
// Board-memory bus between the cell-fetch stage (master) and the board RAM (slave).
//   board_addr  : row*BOARD_COLS+col of the pixel at stage 1
//   board_rdata : colour index, valid one clk after board_addr, held through stalls
//   cell_col    : cell column of the pixel at stage 1
//   cell_row    : cell row of the pixel at stage 1
interface board_cell_fetch_if;
  logic [7:0] board_addr;
  logic [2:0] board_rdata;
  logic [3:0] cell_col;
  logic [4:0] cell_row;

  modport master (output board_addr, output cell_col, output cell_row, input board_rdata);
  modport slave  (input board_addr, input cell_col, input cell_row, output board_rdata);
endinterface

// File: rtl/board_cell_fetch.sv
// Pixel-pipeline stage: tracks board cell column/row and intra-cell offsets with
// counters, fetches the cell colour from board RAM and converts it to RGB, with
// syncs/de delayed to stay aligned with the pixel data (2 pix_en beats).
// Ports:
//   clk, rst_n        : pixel clock, async active-low reset
//   i_pix_en          : pixel strobe, every register advances only when high
//   i_hpos, i_vpos    : current pixel column / line
//   i_de_in           : display enable for (hpos,vpos)
//   i_hsync_in/vsync  : syncs aligned with hpos/vpos
//   bus               : board RAM address/data and stage-1 cell coordinates
//   o_rgb             : {R[1:0],G[1:0],B[1:0]} at stage 2
//   o_de_out/o_hsync_out/o_vsync_out : de/syncs delayed to stage 2
module board_cell_fetch #(
  parameter int unsigned CELL       = 24,
  parameter int unsigned BOARD_COLS = 10,
  parameter int unsigned BOARD_ROWS = 20,
  parameter int unsigned BOARD_X0   = 200,
  parameter int unsigned BOARD_Y0   = 0,
  parameter logic [5:0]  GRID_RGB   = 6'b010101
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_pix_en,
  input  logic [9:0]                i_hpos,
  input  logic [9:0]                i_vpos,
  input  logic                      i_de_in,
  input  logic                      i_hsync_in,
  input  logic                      i_vsync_in,
  board_cell_fetch_if.master        bus,
  output logic [5:0]                o_rgb,
  output logic                      o_de_out,
  output logic                      o_hsync_out,
  output logic                      o_vsync_out
);

  localparam int unsigned OFFW = $clog2(CELL);

  // stage 0 counters
  logic [3:0]      r_col,  w_col_nxt;
  logic [OFFW-1:0] r_xoff, w_xoff_nxt;
  logic            r_in_x, w_in_x_nxt;
  logic [4:0]      r_row,  w_row_nxt;
  logic [OFFW-1:0] r_yoff, w_yoff_nxt;
  logic            r_in_y, w_in_y_nxt;

  // stage 1
  logic [7:0] r_board_addr;
  logic [3:0] r_cell_col;
  logic [4:0] r_cell_row;
  logic       r_inside1, r_edge1, r_de1, r_hs1, r_vs1;
  logic       w_inside, w_edge;
  logic [7:0] w_addr;

  // stage 2
  logic [5:0] r_rgb, w_rgb;
  logic       r_de2, r_hs2, r_vs2;

  // Horizontal cell tracking; restarts at the board's left edge every line.
  always_comb begin
    w_col_nxt  = r_col;
    w_xoff_nxt = r_xoff;
    w_in_x_nxt = r_in_x;
    if (i_hpos == 10'(BOARD_X0)) begin
      w_col_nxt  = 4'd0;
      w_xoff_nxt = '0;
      w_in_x_nxt = 1'b1;
    end else if (r_in_x) begin
      if (r_xoff == OFFW'(CELL - 1)) begin
        w_xoff_nxt = '0;
        if (r_col == 4'(BOARD_COLS - 1)) w_in_x_nxt = 1'b0;
        else                             w_col_nxt  = r_col + 4'd1;
      end else begin
        w_xoff_nxt = r_xoff + OFFW'(1);
      end
    end
  end

  // Vertical cell tracking; only steps at line start (hpos==0).
  always_comb begin
    w_row_nxt  = r_row;
    w_yoff_nxt = r_yoff;
    w_in_y_nxt = r_in_y;
    if (i_hpos == 10'd0) begin
      if (i_vpos == 10'(BOARD_Y0)) begin
        w_row_nxt  = 5'd0;
        w_yoff_nxt = '0;
        w_in_y_nxt = 1'b1;
      end else if ((BOARD_Y0 != 0) && (i_vpos == 10'd0)) begin
        w_in_y_nxt = 1'b0;
      end else if (r_in_y) begin
        if (r_yoff == OFFW'(CELL - 1)) begin
          w_yoff_nxt = '0;
          if (r_row == 5'(BOARD_ROWS - 1)) w_in_y_nxt = 1'b0;
          else                             w_row_nxt  = r_row + 5'd1;
        end else begin
          w_yoff_nxt = r_yoff + OFFW'(1);
        end
      end
    end
  end

  // The presented pixel uses the post-update counter values.
  assign w_inside = w_in_x_nxt & w_in_y_nxt & i_de_in;
  assign w_edge   = (w_xoff_nxt == '0) | (w_yoff_nxt == '0);
  assign w_addr   = 8'(w_row_nxt) * 8'(BOARD_COLS) + 8'(w_col_nxt);

  // Colour index to RGB; index 0 draws grid lines on cell edges only.
  always_comb begin
    w_rgb = 6'b000000;
    if (r_de1 && r_inside1) begin
      case (bus.board_rdata)
        3'd1:    w_rgb = 6'b001111;
        3'd2:    w_rgb = 6'b111100;
        3'd3:    w_rgb = 6'b110011;
        3'd4:    w_rgb = 6'b001100;
        3'd5:    w_rgb = 6'b110000;
        3'd6:    w_rgb = 6'b000011;
        3'd7:    w_rgb = 6'b111000;
        default: w_rgb = r_edge1 ? GRID_RGB : 6'b000000;
      endcase
    end
  end

  // All pipeline state; frozen while pix_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_xoff       <= '0;
      r_in_x       <= 1'b0;
      r_row        <= '0;
      r_yoff       <= '0;
      r_in_y       <= 1'b0;
      r_board_addr <= '0;
      r_cell_col   <= '0;
      r_cell_row   <= '0;
      r_inside1    <= 1'b0;
      r_edge1      <= 1'b0;
      r_de1        <= 1'b0;
      r_hs1        <= 1'b0;
      r_vs1        <= 1'b0;
      r_rgb        <= '0;
      r_de2        <= 1'b0;
      r_hs2        <= 1'b0;
      r_vs2        <= 1'b0;
    end else if (i_pix_en) begin
      r_col      <= w_col_nxt;
      r_xoff     <= w_xoff_nxt;
      r_in_x     <= w_in_x_nxt;
      r_row      <= w_row_nxt;
      r_yoff     <= w_yoff_nxt;
      r_in_y     <= w_in_y_nxt;
      if (w_inside) r_board_addr <= w_addr;
      r_cell_col <= w_col_nxt;
      r_cell_row <= w_row_nxt;
      r_inside1  <= w_inside;
      r_edge1    <= w_edge;
      r_de1      <= i_de_in;
      r_hs1      <= i_hsync_in;
      r_vs1      <= i_vsync_in;
      r_rgb      <= w_rgb;
      r_de2      <= r_de1;
      r_hs2      <= r_hs1;
      r_vs2      <= r_vs1;
    end
  end

  assign bus.board_addr = r_board_addr;
  assign bus.cell_col   = r_cell_col;
  assign bus.cell_row   = r_cell_row;
  assign o_rgb          = r_rgb;
  assign o_de_out       = r_de2;
  assign o_hsync_out    = r_hs2;
  assign o_vsync_out    = r_vs2;

endmodule
